// File: rtl/sync_with_ack.sv
// Receive endpoint of a 4-phase req/ack handshake: synchronizes a_vld_in into clk_a,
// returns the synchronized level as a_rdy_out, and emits one b_vld_out pulse per request.
// Optional pulse counter enabled by defining SYNC_WITH_ACK_CNT_EN; evt_count reads 0 otherwise.
module sync_with_ack #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk_a,
    input  logic             a_reset_in,
    input  logic             a_vld_in,
    output logic             a_rdy_out,
    output logic             b_vld_out,
    output logic [CNT_W-1:0] evt_count
);

    logic [SYNC_STAGES-1:0] s;
    logic                   h;

    // Plain flop chain with no logic between stages to give metastability time to settle.
    always_ff @(posedge clk_a or negedge a_reset_in) begin
        if (!a_reset_in) begin
            s         <= '0;
            h         <= 1'b0;
            b_vld_out <= 1'b0;
        end else begin
            s         <= {s[SYNC_STAGES-2:0], a_vld_in};
            h         <= s[SYNC_STAGES-1];
            b_vld_out <= s[SYNC_STAGES-1] & ~h;
        end
    end

    assign a_rdy_out = h;

`ifdef SYNC_WITH_ACK_CNT_EN
    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk_a or negedge a_reset_in) begin
        if (!a_reset_in)
            cnt <= '0;
        else if (b_vld_out)
            cnt <= cnt + CNT_W'(1);
    end

    assign evt_count = cnt;
`else
    assign evt_count = '0;
`endif

endmodule

// File: tb/tb_sync_with_ack.sv
// Bench for sync_with_ack: delay-line reference model checked every cycle on two DUTs
// (8-bit and 4-bit counters) plus directed handshake, reset and wrap checks.
module tb_sync_with_ack;

    localparam int SYNC = 2;
`ifdef SYNC_WITH_ACK_CNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    logic       tb_clk_A;
    logic       a_reset_in;
    logic       a_vld_in;
    logic       a_rdy_out,  b_vld_out;
    logic       a_rdy_w,    b_vld_w;
    logic [7:0] evt_count;
    logic [3:0] evt_count_w;

    int checks = 0;
    int errors = 0;
    int pulse_cnt = 0;

    sync_with_ack #(.SYNC_STAGES(SYNC), .CNT_W(8)) dut (
        .clk_a(tb_clk_A), .a_reset_in(a_reset_in), .a_vld_in(a_vld_in),
        .a_rdy_out(a_rdy_out), .b_vld_out(b_vld_out), .evt_count(evt_count));

    sync_with_ack #(.SYNC_STAGES(SYNC), .CNT_W(4)) dut_w (
        .clk_a(tb_clk_A), .a_reset_in(a_reset_in), .a_vld_in(a_vld_in),
        .a_rdy_out(a_rdy_w), .b_vld_out(b_vld_w), .evt_count(evt_count_w));

    initial begin
        tb_clk_A = 1'b0;
        forever #5 tb_clk_A = ~tb_clk_A;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: rdy after edge n is the level sampled S edges earlier; a pulse is a
    // 0->1 step in that delayed sample; the count adds last edge's pulse.
    bit         hist[$];
    logic [7:0] m_cnt8;
    logic [3:0] m_cnt4;
    bit         exp_rdy, exp_b;

    always @(posedge tb_clk_A) begin
        if (!a_reset_in) begin
            hist.delete();
            for (int i = 0; i < SYNC + 2; i++) hist.push_back(1'b0);
            m_cnt8 = '0;
            m_cnt4 = '0;
        end else begin
            if (hist[SYNC] && !hist[SYNC+1]) begin
                m_cnt8 = m_cnt8 + 8'd1;
                m_cnt4 = m_cnt4 + 4'd1;
            end
            hist.push_front(a_vld_in);
            void'(hist.pop_back());
        end
        #1;
        exp_rdy = hist[SYNC];
        exp_b   = hist[SYNC] && !hist[SYNC+1];
        chk("model_rdy",   {31'd0, a_rdy_out}, {31'd0, exp_rdy});
        chk("model_b",     {31'd0, b_vld_out}, {31'd0, exp_b});
        chk("model_rdy_w", {31'd0, a_rdy_w},   {31'd0, exp_rdy});
        chk("model_b_w",   {31'd0, b_vld_w},   {31'd0, exp_b});
        chk("model_cnt8",  {24'd0, evt_count},   CNT_ON ? {24'd0, m_cnt8} : 32'd0);
        chk("model_cnt4",  {28'd0, evt_count_w}, CNT_ON ? {28'd0, m_cnt4} : 32'd0);
        if (b_vld_out === 1'b1) pulse_cnt++;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge tb_clk_A);
    endtask

    task automatic do_reset(input int cyc);
        a_reset_in = 1'b0;
        tick(cyc);
        a_reset_in = 1'b1;
    endtask

    task automatic handshake();
        int t;
        a_vld_in = 1'b1;
        t = 0;
        while (b_vld_out !== 1'b1 && t < 20) begin tick(1); t++; end
        chk("hs_pulse_seen", {31'd0, b_vld_out}, 32'd1);
        tick(1);
        a_vld_in = 1'b0;
        t = 0;
        while (a_rdy_out !== 1'b0 && t < 20) begin tick(1); t++; end
        chk("hs_rdy_drop", {31'd0, a_rdy_out}, 32'd0);
        tick($urandom_range(0, 2));
    endtask

    initial begin
        int p0, t, hold;
        a_reset_in = 1'b0;
        a_vld_in   = 1'b1;

        // Reset held with request high: everything stays clear.
        for (int i = 0; i < 3; i++) begin
            tick(1);
            chk("rst_rdy", {31'd0, a_rdy_out}, 32'd0);
            chk("rst_b",   {31'd0, b_vld_out}, 32'd0);
            chk("rst_cnt", {24'd0, evt_count}, 32'd0);
        end
        a_reset_in = 1'b1;
        tick(2);
        chk("rel_b_early", {31'd0, b_vld_out}, 32'd0);
        tick(1);
        chk("rel_b_pulse", {31'd0, b_vld_out}, 32'd1);
        chk("rel_rdy",     {31'd0, a_rdy_out}, 32'd1);
        tick(1);
        chk("rel_b_one",   {31'd0, b_vld_out}, 32'd0);
        chk("rel_cnt",     {24'd0, evt_count}, CNT_ON ? 32'd1 : 32'd0);
        a_vld_in = 1'b0;
        tick(4);

        // Asynchronous clear between clock edges.
        a_vld_in = 1'b1;
        tick(3);
        #2 a_reset_in = 1'b0;
        #1;
        chk("async_rdy", {31'd0, a_rdy_out}, 32'd0);
        chk("async_b",   {31'd0, b_vld_out}, 32'd0);
        chk("async_cnt", {24'd0, evt_count}, 32'd0);
        @(negedge tb_clk_A);
        a_vld_in = 1'b0;
        tick(2);
        a_reset_in = 1'b1;
        tick(2);

        // One-cycle request pulse.
        a_vld_in = 1'b1;
        tick(1);
        a_vld_in = 1'b0;
        tick(1);
        chk("sp_b_e1", {31'd0, b_vld_out}, 32'd0);
        tick(1);
        chk("sp_b_e2",   {31'd0, b_vld_out}, 32'd1);
        chk("sp_rdy_e2", {31'd0, a_rdy_out}, 32'd1);
        tick(1);
        chk("sp_b_e3",   {31'd0, b_vld_out}, 32'd0);
        chk("sp_rdy_e3", {31'd0, a_rdy_out}, 32'd0);
        tick(2);

        // Full 4-phase handshake; ack falls two edges after the drop.
        p0 = pulse_cnt;
        a_vld_in = 1'b1;
        t = 0;
        while (a_rdy_out !== 1'b1 && t < 20) begin tick(1); t++; end
        chk("fh_rdy_high", {31'd0, a_rdy_out}, 32'd1);
        a_vld_in = 1'b0;
        tick(2);
        chk("fh_rdy_hold", {31'd0, a_rdy_out}, 32'd1);
        tick(1);
        chk("fh_rdy_fall", {31'd0, a_rdy_out}, 32'd0);
        tick(2);
        chk("fh_pulses", pulse_cnt - p0, 32'd1);

        // 16 back-to-back handshakes, then one more to wrap the 4-bit counter.
        do_reset(2);
        p0 = pulse_cnt;
        for (int i = 0; i < 16; i++) handshake();
        tick(2);
        chk("b2b_pulses", pulse_cnt - p0, 32'd16);
        chk("b2b_cnt8", {24'd0, evt_count},   CNT_ON ? 32'd16 : 32'd0);
        chk("b2b_cnt4", {28'd0, evt_count_w}, 32'd0);
        handshake();
        tick(2);
        chk("wrap_cnt8", {24'd0, evt_count},   CNT_ON ? 32'd17 : 32'd0);
        chk("wrap_cnt4", {28'd0, evt_count_w}, CNT_ON ? 32'd1 : 32'd0);

        // Reset at E0+1 drops the in-flight request; a still-high request pulses after release.
        do_reset(2);
        p0 = pulse_cnt;
        a_vld_in = 1'b1;
        tick(2);
        a_reset_in = 1'b0;
        tick(2);
        chk("mid_b",      {31'd0, b_vld_out}, 32'd0);
        chk("mid_cnt",    {24'd0, evt_count}, 32'd0);
        chk("mid_pulses", pulse_cnt - p0, 32'd0);
        a_reset_in = 1'b1;
        tick(2);
        chk("mid_rel_early", {31'd0, b_vld_out}, 32'd0);
        tick(1);
        chk("mid_rel_pulse", {31'd0, b_vld_out}, 32'd1);
        tick(1);
        chk("mid_rel_count", pulse_cnt - p0, 32'd1);
        a_vld_in = 1'b0;
        tick(4);

        // Random levels, including narrow and protocol-violating requests and stray resets.
        for (int i = 0; i < 200; i++) begin
            a_vld_in = 1'($urandom_range(0, 1));
            hold = $urandom_range(1, 6);
            if ($urandom_range(0, 39) == 0) begin
                a_reset_in = 1'b0;
                tick(1);
                a_reset_in = 1'b1;
            end
            tick(hold);
        end
        a_vld_in = 1'b0;
        tick(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/sync_with_ack.md
# sync_with_ack

Synchronizing receiver for an asynchronous request/acknowledge (4-phase) handshake. An asynchronous request level on `a_vld_in` is synchronized into the `clk_a` domain and converted into a single-cycle valid pulse on `b_vld_out`. The synchronized level is returned to the sender as the acknowledge `a_rdy_out`. The block sits at a clock-domain boundary as the receive endpoint; an optional pulse counter supports debug and bring-up.

## Interface
- `SYNC_STAGES`, default 2: number of synchronizer flops on `a_vld_in`. Legal range is 2..4.
- `CNT_W`, default 8: width of the accepted-event counter.

Ports:
- `clk_a`, input, 1 bit: the block's single clock. All flops are rising-edge.
- `a_reset_in`, input, 1 bit: reset, asynchronous and active-low.
- `a_vld_in`, input, 1 bit: request level from the sender. It is asynchronous to `clk_a`.
- `a_rdy_out`, output, 1 bit: acknowledge level, i.e. the synchronized and registered `a_vld_in`.
- `b_vld_out`, output, 1 bit: one-cycle pulse, once per request rising edge.
- `evt_count`, output, `CNT_W` bits: number of `b_vld_out` pulses issued, modulo 2^`CNT_W`.

## Operation
- Synchronizer chain `s[0..SYNC_STAGES-1]`: `s[0]` <= `a_vld_in`, and each `s[i]` <= `s[i-1]`. There is no logic between stages.
- History register `h` <= `s[SYNC_STAGES-1]`.
- `a_rdy_out` is driven directly from `h` (registered).
- `b_vld_out` is a registered output equal to `s[SYNC_STAGES-1] & ~h`. It goes high for exactly one cycle per 0->1 transition of the synchronized request.
- A 1->0 request transition produces no pulse. It only drops `a_rdy_out`.
- Sender protocol (4-phase):
  - raise `a_vld_in`;
  - hold it until `a_rdy_out`=1, or at minimum one full `clk_a` period;
  - drop it;
  - wait for `a_rdy_out`=0 before the next request.
- A request pulse at least one `clk_a` period wide is guaranteed to be captured.
- Pulses narrower than that may be lost. The block neither detects nor flags this.
- Requests re-raised before `a_rdy_out` returns low are merged or missed. No error indication is produced.
- `evt_count` increments on every cycle in which `b_vld_out` is 1 and wraps from all-ones to 0.

## Timing
- Reset (`a_reset_in`=0) asynchronously clears `s`, `h`, `b_vld_out` and `evt_count` to 0, so `a_rdy_out`=0, `b_vld_out`=0 and `evt_count`=0 immediately.
- Reset release is synchronous to the next rising edge of `clk_a`.
- Let edge E0 be the first rising edge that samples `a_vld_in`=1. Then:
  - `s[SYNC_STAGES-1]` goes high at edge E0+(`SYNC_STAGES`-1);
  - `b_vld_out` goes high at E0+`SYNC_STAGES` and low at E0+`SYNC_STAGES`+1;
  - `a_rdy_out` goes high at E0+`SYNC_STAGES`, the same edge as `b_vld_out`.
- With the default `SYNC_STAGES`=2, `b_vld_out` appears 2 edges after capture.
- Fall path: if the first edge sampling `a_vld_in`=0 is F0, `a_rdy_out` goes low at F0+`SYNC_STAGES`.
- Request rate: the minimum full handshake is 2*(`SYNC_STAGES`+1) cycles.
- If reset is asserted mid-handshake, the in-flight request is dropped, with no pulse and no count. After release, a still-high `a_vld_in` is treated as a new rising edge and generates one pulse.

## Configuration
- The macro `SYNC_WITH_ACK_CNT_EN` controls the counter.
- When it is defined, the `evt_count` counter is implemented as described above.
- When it is not defined, no counter flops are built, `evt_count` is tied to 0, and the port list is unchanged.
- Synchronizer, pulse and acknowledge behaviour are identical in both builds.

## Test plan
- Reset: hold `a_reset_in`=0 with `a_vld_in`=1, then check `a_rdy_out`=0, `b_vld_out`=0 and `evt_count`=0 throughout. After release, expect exactly one pulse 2 edges later.
- Single pulse: after reset, drive `a_vld_in` high for 1 cycle. Expect `b_vld_out` high for exactly one cycle at E0+2 and `a_rdy_out` high only during E0+2..E0+2.
- Full 4-phase handshake: hold the request until `a_rdy_out`=1, then drop it. Expect one pulse only, and `a_rdy_out` to fall 2 edges after the drop.
- 16 back-to-back handshakes, each waiting for `b_vld_out` then one extra cycle. Expect exactly 16 pulses and `evt_count`=16 (0 when the counter macro is undefined).
- Counter wrap with `CNT_W`=4: run 17 handshakes and expect `evt_count`=1.
- Mid-operation reset: assert reset at E0+1. Expect no pulse and `evt_count` unchanged from 0. After release with the request still high, expect one pulse.
